// File: rtl/mprj_loader_pkg.sv
// ============================================================================
// Module : mprj_loader_pkg
// Brief  : State encoding and LOAD-phase strobe tables for the serial loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mprj_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LOAD     = 3'd4
  } state_t;

  localparam int unsigned c_LOAD_PHASES = 4;

  // Indexed by LOAD phase 0..3: (clk,rstn) = (1,1) (1,0) (1,1) (0,1)
  localparam logic [c_LOAD_PHASES-1:0] c_LOAD_SCLK  = 4'b0111;
  localparam logic [c_LOAD_PHASES-1:0] c_LOAD_SRSTN = 4'b1101;

endpackage

`default_nettype wire

// File: rtl/mprj_loader_clkdiv.sv
// ============================================================================
// Module : mprj_loader_clkdiv
// Brief  : Phase-tick generator; tick fires on the (div+1)th cycle of a phase.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mprj_loader_clkdiv #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             restart,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;

  assign tick = (r_cnt == div) && !restart && !abort;

  // Counter clears on tick, so at div = all-ones it never wraps past div
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (restart || abort || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mprj_serial_loader.sv
// ============================================================================
// Module : mprj_serial_loader
// Brief  : Shifts per-pad control words MSB-first onto N parallel serial chains
//          and issues a load strobe. Optional: SERIAL_LOADER_PARITY_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mprj_serial_loader
  import mprj_loader_pkg::*;
#(
  parameter int N_CHAINS       = 2,
  parameter int PADS_PER_CHAIN = 19,
  parameter int CTRL_BITS      = 13,
  parameter int DIV_W          = 8,
  parameter int POS_W          = (PADS_PER_CHAIN > 1) ? $clog2(PADS_PER_CHAIN) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DIV_W-1:0]              div,
  output logic [POS_W-1:0]              cfg_rd_pos,
  input  logic [N_CHAINS*CTRL_BITS-1:0] cfg_rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          serial_clock,
  output logic                          serial_resetn,
  output logic [N_CHAINS-1:0]           serial_data_out
`ifdef SERIAL_LOADER_PARITY_EN
  ,
  output logic [N_CHAINS-1:0]           parity
`endif
);

  localparam int BIT_W = (CTRL_BITS > 1) ? $clog2(CTRL_BITS) : 1;
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(CTRL_BITS - 1);
  localparam logic [BIT_W-1:0] c_BIT_ONE  = BIT_W'(1);
  localparam logic [POS_W-1:0] c_POS_LAST = POS_W'(PADS_PER_CHAIN - 1);
  localparam logic [POS_W-1:0] c_POS_ONE  = POS_W'(1);
  localparam logic [1:0]       c_PH_LAST  = 2'(c_LOAD_PHASES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_div;
  logic [POS_W-1:0] r_pos;
  logic [BIT_W-1:0] r_bit;
  logic [1:0]       r_phase;
  logic             r_done;
  logic             r_out_en;
  logic             w_tick;
  logic             w_abort;
  logic             w_restart;
  logic             w_shift;

  assign w_abort   = abort && (r_state != IDLE);
  assign w_restart = (r_state == IDLE) || (r_state == FETCH);
  assign w_shift   = (r_state == SHIFT_HI) && w_tick;

  mprj_loader_clkdiv #(
    .DIV_W (DIV_W)
  ) u_clkdiv (
    .clk     (clk),
    .resetn  (resetn),
    .restart (w_restart),
    .abort   (w_abort),
    .div     (r_div),
    .tick    (w_tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = FETCH;
      FETCH:    w_next = SHIFT_LO;
      SHIFT_LO: if (w_tick) w_next = SHIFT_HI;
      SHIFT_HI: begin
        if (w_tick) begin
          if (r_bit != c_BIT_LAST) w_next = SHIFT_LO;
          else if (r_pos != '0)    w_next = FETCH;
          else                     w_next = LOAD;
        end
      end
      LOAD:     if (w_tick && (r_phase == c_PH_LAST)) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div    <= '0;
      r_pos    <= '0;
      r_bit    <= '0;
      r_phase  <= '0;
      r_done   <= 1'b0;
      r_out_en <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      r_done   <= (r_state == LOAD) && w_tick && (r_phase == c_PH_LAST);
      case (r_state)
        IDLE: begin
          r_phase <= '0;
          if (start) begin
            r_div <= div;
            r_pos <= c_POS_LAST;
          end
        end
        FETCH: r_bit <= '0;
        SHIFT_HI: begin
          if (w_tick) begin
            if (r_bit != c_BIT_LAST) r_bit <= r_bit + c_BIT_ONE;
            else if (r_pos != '0)    r_pos <= r_pos - c_POS_ONE;
          end
        end
        LOAD: if (w_tick) r_phase <= r_phase + 2'd1;
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < N_CHAINS; c++) begin : g_chain
    logic [CTRL_BITS-1:0] r_stage;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_stage <= '0;
      end else if (w_abort) begin
        r_stage <= '0;
      end else if (r_state == FETCH) begin
        r_stage <= cfg_rd_data[c*CTRL_BITS +: CTRL_BITS];
      end else if (w_shift) begin
        r_stage <= r_stage << 1;
      end
    end

    assign serial_data_out[c] = r_stage[CTRL_BITS-1];
  end

`ifdef SERIAL_LOADER_PARITY_EN
  logic [N_CHAINS-1:0] r_parity;

  // Accumulate the bit presented as serial_clock rises into SHIFT_HI
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_parity <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_parity <= '0;
    end else if ((r_state == SHIFT_LO) && w_tick) begin
      r_parity <= r_parity ^ serial_data_out;
    end
  end

  assign parity = r_parity;
`endif

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign cfg_rd_pos    = r_pos;
  assign serial_clock  = (r_state == SHIFT_HI) ||
                         ((r_state == LOAD) && c_LOAD_SCLK[r_phase]);
  assign serial_resetn = r_out_en &&
                         !((r_state == LOAD) && !c_LOAD_SRSTN[r_phase]);

endmodule

`default_nettype wire

// File: tb/tb_mprj_serial_loader.sv
// ============================================================================
// Module : tb_mprj_serial_loader
// Brief  : Randomized self-checking bench for mprj_serial_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mprj_serial_loader;

  localparam int P      = 19;
  localparam int C      = 13;
  localparam int N      = 2;
  localparam int DW     = 8;
  localparam int PW     = 5;
  localparam int BUDGET = 10000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          abort;
  logic [DW-1:0] div;
  logic [PW-1:0] cfg_rd_pos;
  logic [N*C-1:0] cfg_rd_data;
  logic          busy;
  logic          done;
  logic          serial_clock;
  logic          serial_resetn;
  logic [N-1:0]  serial_data_out;
`ifdef SERIAL_LOADER_PARITY_EN
  logic [N-1:0]  parity;
`endif

  always #5 clk = ~clk;

  mprj_serial_loader #(
    .N_CHAINS       (N),
    .PADS_PER_CHAIN (P),
    .CTRL_BITS      (C),
    .DIV_W          (DW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .abort           (abort),
    .div             (div),
    .cfg_rd_pos      (cfg_rd_pos),
    .cfg_rd_data     (cfg_rd_data),
    .busy            (busy),
    .done            (done),
    .serial_clock    (serial_clock),
    .serial_resetn   (serial_resetn),
    .serial_data_out (serial_data_out)
`ifdef SERIAL_LOADER_PARITY_EN
    ,
    .parity          (parity)
`endif
  );

  logic [C-1:0] words [P][N];

  always_comb begin
    cfg_rd_data = '0;
    for (int c = 0; c < N; c++)
      if (int'(cfg_rd_pos) < P) cfg_rd_data[c*C +: C] = words[cfg_rd_pos][c];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observations from the most recent transfer
  logic [N-1:0] data_q [$];
  int           hi_q   [$];
  int busy_cnt, lo_first, rn_low, rn_low_bad, done_in_busy;
  logic done_after;

  function automatic int exp_busy(input int d);
    return P * (1 + 2 * C * (d + 1)) + 4 * (d + 1);
  endfunction

  function automatic int stream_errors();
    int e = 0;
    for (int i = 0; i < data_q.size(); i++) begin
      int p = P - 1 - i / C;
      int b = C - 1 - i % C;
      for (int c = 0; c < N; c++)
        if (p >= 0 && data_q[i][c] !== words[p][c][b]) e++;
    end
    return e;
  endfunction

  function automatic int hi_len_errors(input int d);
    int e = 0;
    for (int i = 0; i < hi_q.size(); i++) begin
      int want = (i == hi_q.size() - 1) ? 4 * (d + 1) : d + 1;
      if (hi_q[i] != want) e++;
    end
    return e;
  endfunction

  function automatic logic [N-1:0] exp_parity();
    logic [N-1:0] x = '0;
    for (int p = 0; p < P; p++)
      for (int c = 0; c < N; c++) x[c] = x[c] ^ (^words[p][c]);
    return x;
  endfunction

  task automatic fill_pattern();
    for (int p = 0; p < P; p++)
      for (int c = 0; c < N; c++) words[p][c] = C'(13'h1000 | p);
  endtask

  task automatic fill_random();
    for (int p = 0; p < P; p++)
      for (int c = 0; c < N; c++) words[p][c] = C'($urandom);
  endtask

  task automatic fill_const(input logic [C-1:0] v);
    for (int p = 0; p < P; p++)
      for (int c = 0; c < N; c++) words[p][c] = v;
  endtask

  task automatic run_xfer(input int d, input int abort_at, input int restart_at,
                          input bit abort_with_start);
    int   cyc = 0;
    int   hi_len = 0;
    bit   seen_rise = 0;
    logic prev_sclk = 1'b0;
    logic prev_srn = 1'b1;
    data_q.delete();
    hi_q.delete();
    busy_cnt = 0; lo_first = 0; rn_low = 0; rn_low_bad = 0; done_in_busy = 0;
    div = DW'(d);
    start = 1'b1;
    abort = abort_with_start;
    step();
    start = 1'b0;
    abort = 1'b0;
    div = DW'($urandom);
    while (busy && cyc < BUDGET) begin
      busy_cnt++;
      if (serial_clock && !prev_sclk) begin
        data_q.push_back(serial_data_out);
        seen_rise = 1;
      end
      if (!seen_rise) lo_first++;
      if (serial_clock) hi_len++;
      else if (hi_len > 0) begin
        hi_q.push_back(hi_len);
        hi_len = 0;
      end
      if (!serial_resetn && prev_srn) begin
        rn_low++;
        if (!serial_clock) rn_low_bad++;
      end
      if (done) done_in_busy++;
      prev_sclk = serial_clock;
      prev_srn  = serial_resetn;
      start = (cyc == restart_at);
      abort = (cyc == abort_at);
      step();
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    if (hi_len > 0) hi_q.push_back(hi_len);
    check("xfer_terminates", 32'(busy), 32'd0);
    done_after = done;
  endtask

  task automatic check_complete(input string tag, input int d);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy(d));
    check({tag, "_bit_count"}, data_q.size(), P * C);
    check({tag, "_stream"}, stream_errors(), 0);
    check({tag, "_lo_first"}, lo_first, d + 2);
    check({tag, "_hi_lengths"}, hi_len_errors(d), 0);
    check({tag, "_srn_low_phases"}, rn_low, 1);
    check({tag, "_srn_low_sclk"}, rn_low_bad, 0);
    check({tag, "_done_pulse"}, 32'(done_after), 32'd1);
    check({tag, "_no_early_done"}, done_in_busy, 0);
`ifdef SERIAL_LOADER_PARITY_EN
    check({tag, "_parity"}, 32'(parity), 32'(exp_parity()));
`endif
    step();
    check({tag, "_done_single"}, 32'(done), 32'd0);
`ifdef SERIAL_LOADER_PARITY_EN
    check({tag, "_parity_held"}, 32'(parity), 32'(exp_parity()));
`endif
  endtask

  initial begin
    logic [C-1:0] first;
    int guard;
    resetn = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    div    = '0;
    fill_pattern();
    repeat (2) @(posedge clk);
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sclk", 32'(serial_clock), 32'd0);
    check("rst_srn", 32'(serial_resetn), 32'd0);
    check("rst_sdo", 32'(serial_data_out), 32'd0);
    check("rst_pos", 32'(cfg_rd_pos), 32'd0);
    resetn = 1'b1;
    step();
    check("rst_release_srn", 32'(serial_resetn), 32'd1);

    // Fixed pattern, div=0
    run_xfer(0, -1, -1, 1'b0);
    first = '0;
    for (int i = 0; i < C && i < data_q.size(); i++) first[C-1-i] = data_q[i][0];
    check("pattern_first_bits", 32'(first), 32'h1012);
    check_complete("pattern", 0);

    // Random words, div=3
    fill_random();
    run_xfer(3, -1, -1, 1'b0);
    check_complete("div3", 3);

    // Abort mid-transfer, then a clean restart
    fill_random();
    run_xfer(0, 100, -1, 1'b0);
    check("abort_busy", busy_cnt, 101);
    check("abort_no_srn_low", rn_low, 0);
    check("abort_no_done", 32'(done_after), 32'd0);
    check("abort_sclk", 32'(serial_clock), 32'd0);
    step();
    check("abort_no_late_done", 32'(done), 32'd0);
    begin
      int d = $urandom_range(0, 2);
      fill_random();
      run_xfer(d, -1, -1, 1'b0);
      check_complete("after_abort", d);
    end

    // Second start mid-transfer is ignored
    fill_random();
    run_xfer(0, -1, 50, 1'b0);
    check_complete("restart_ignored", 0);
    check("restart_idle", 32'(busy), 32'd0);

    // start and abort together in IDLE
    fill_random();
    run_xfer(1, -1, -1, 1'b1);
    check_complete("start_abort", 1);

    // Full-range divider, cut short by abort
    fill_random();
    run_xfer(255, 600, -1, 1'b0);
    check("divmax_lo_first", lo_first, 257);
    check("divmax_hi_first", (hi_q.size() > 0) ? hi_q[0] : -1, 256);
    check("divmax_busy", busy_cnt, 601);

`ifdef SERIAL_LOADER_PARITY_EN
    fill_const(C'(1));
    run_xfer(0, -1, -1, 1'b0);
    check("parity_ones", 32'(parity), {{(32-N){1'b0}}, {N{1'b1}}});
    check_complete("parity_ones_x", 0);
`endif

    // Asynchronous reset during SHIFT_HI
    fill_pattern();
    div = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!serial_clock && guard < 50) begin
      step();
      guard++;
    end
    check("reset_reach_shift_hi", 32'(serial_clock), 32'd1);
    #3 resetn = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_sclk", 32'(serial_clock), 32'd0);
    check("async_srn", 32'(serial_resetn), 32'd0);
    check("async_sdo", 32'(serial_data_out), 32'd0);
    check("async_pos", 32'(cfg_rd_pos), 32'd0);
    check("async_done", 32'(done), 32'd0);
    #2 resetn = 1'b1;
    #1;
    check("release_srn_before_edge", 32'(serial_resetn), 32'd0);
    step();
    check("release_srn_after_edge", 32'(serial_resetn), 32'd1);
    check("release_idle", 32'(busy), 32'd0);
    check("release_no_done", 32'(done), 32'd0);

    fill_random();
    run_xfer(0, -1, -1, 1'b0);
    check_complete("post_reset", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mprj_serial_loader.md
MPRJ_SERIAL_LOADER -- requirements
Module: mprj_serial_loader

Interface
REQ-001 SHALL have parameter N_CHAINS, default 2: number of independent serial configuration chains.
REQ-002 SHALL have parameter PADS_PER_CHAIN, default 19: number of pads on each chain.
REQ-003 SHALL have parameter CTRL_BITS, default 13: width of each pad control word.
REQ-004 SHALL have parameter DIV_W, default 8: width of the clock-divider input.
REQ-005 Port clk, input, 1: the single clock.
REQ-006 Port resetn, input, 1: reset, asynchronous and active-low.
REQ-007 Port start, input, 1: single-cycle request to begin a transfer.
REQ-008 Port abort, input, 1: terminates a transfer with no load pulse.
REQ-009 Port div, input, DIV_W: half-period of serial_clock is div+1 clk cycles.
REQ-010 Port cfg_rd_pos, output, clog2(PADS_PER_CHAIN): chain position being fetched.
REQ-011 Port cfg_rd_data, input, N_CHAINS*CTRL_BITS: control words for cfg_rd_pos; chain c occupies slice c; combinational, same-cycle.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.
REQ-013 Port done, output, 1: single-cycle pulse when a load completes.
REQ-014 Port serial_clock, output, 1: shared shift clock.
REQ-015 Port serial_resetn, output, 1: shared load/reset strobe.
REQ-016 Port serial_data_out, output, N_CHAINS: per-chain data, bit c = MSB of staging word c.

Function
REQ-017 States SHALL be IDLE, FETCH, SHIFT_LO, SHIFT_HI and LOAD.
REQ-018 IDLE: serial_clock=0, serial_resetn=1; start=1 latches div, sets pos=PADS_PER_CHAIN-1, and enters FETCH next cycle.
REQ-019 FETCH lasts 1 cycle: cfg_rd_pos=pos; all staging words load from cfg_rd_data; bit counter=0; next state SHIFT_LO.
REQ-020 SHIFT_LO lasts div+1 cycles with serial_clock=0, then goes to SHIFT_HI.
REQ-021 SHIFT_HI lasts div+1 cycles with serial_clock=1; on exit, staging words shift left by one bit, zero-filled.
REQ-022 Exit from SHIFT_HI SHALL go to:
  - SHIFT_LO if the bit counter is below CTRL_BITS-1 (counter incremented);
  - FETCH with pos-1 if the bit counter equals CTRL_BITS-1 and pos>0;
  - LOAD if the bit counter equals CTRL_BITS-1 and pos==0.
REQ-023 Bit order: MSB first; the farthest position (PADS_PER_CHAIN-1) is shifted first and position 0 last.
REQ-024 LOAD SHALL run four phases of div+1 cycles each, as (serial_clock, serial_resetn): (1,1), (1,0), (1,1), (0,1); it then returns to IDLE with done=1 for that first IDLE cycle.
REQ-025 Latency at div=0 SHALL be PADS_PER_CHAIN*(1+2*CTRL_BITS)+4 busy cycles; this is 517 with default parameters.
REQ-026 start while busy SHALL be ignored; the div input is not re-sampled mid-transfer.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle (serial_clock=0, serial_resetn=1, done=0); abort has priority over phase completion.
REQ-028 start and abort asserted together in IDLE: abort is ignored and the transfer starts.
REQ-029 The divider counter SHALL be DIV_W bits; at div=2^DIV_W-1 it SHALL count full-range without overflow misbehaviour.

Reset
REQ-030 While resetn=0, outputs SHALL be: state IDLE, busy=0, done=0, serial_clock=0, serial_resetn=0, serial_data_out=0, cfg_rd_pos=0.
REQ-031 On the first clk edge after release, serial_resetn SHALL go to 1.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer immediately with no done.

Configuration
REQ-033 With SERIAL_LOADER_PARITY_EN defined:
  - adds output parity, N_CHAINS wide, cleared on start;
  - each bit XOR-accumulates every data bit driven on its chain at SHIFT_HI entry;
  - the value is held stable from the done pulse until the next start.
REQ-034 Without SERIAL_LOADER_PARITY_EN, the parity port and its logic SHALL be absent.

Structure
REQ-035 Package mprj_loader_pkg SHALL hold the state typedef and the LOAD phase constants.
REQ-036 Sub-module mprj_loader_clkdiv SHALL provide the div+1 phase-tick generator, with restart and abort inputs.

Verification
REQ-037 Defaults, div=0, position-p word = 13'h1000|p for both chains, single start: busy for exactly 517 cycles; chain 0 first bits are 1,0,0,0,0,0,0,0,1,0,0,1,0 (pos 18); exactly one serial_resetn low phase, occurring while serial_clock=1; done pulses once.
REQ-038 div=3: every serial_clock high and low phase measures 4 cycles; total busy = 19*(1+104)+16 = 2011 cycles.
REQ-039 abort 100 cycles after start: IDLE next cycle, no serial_resetn low, no done; a new start then completes normally.
REQ-040 start pulsed again at cycle 50 of a transfer: ignored, total busy unchanged at 517 cycles.
REQ-041 resetn dropped mid-SHIFT_HI: outputs take reset values asynchronously (without waiting for a clk edge); serial_resetn returns to 1 one cycle after release.
REQ-042 With SERIAL_LOADER_PARITY_EN, all words 13'h0001: parity = PADS_PER_CHAIN mod 2 = 1 on every chain at done.
